wb_mtimer: RTL
==============

WB_MTIMER -- requirements
Module: wb_mtimer

Interface
REQ-001 Parameter RESET_CMP, default 64'hFFFF_FFFF_FFFF_FFFF, is the reset value of mtimecmp.
REQ-002 Parameter RESET_DIV, default 8'd0, is the reset prescale divider (0 = increment every cycle).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 wb_clk_i  in  1  bus and timer clock.
REQ-005 wb_rst_i  in  1  asynchronous active-high reset.
REQ-006 wb_adr_i  in  32  byte address; only [4:2] is decoded.
REQ-007 wb_dat_i  in  32  write data.
REQ-008 wb_sel_i  in  4  byte lane enables.
REQ-009 wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  Wishbone classic control.
REQ-010 wb_cti_i  in  3, wb_bte_i  in  2: accepted and ignored; every access is treated as classic.
REQ-011 wb_dat_o  out  32  read data; wb_ack_o, wb_err_o, wb_rty_o  out  1 each  cycle termination.
REQ-012 irq_o  out  1  level timer interrupt.

Function
REQ-013 Register map, word index adr[4:2]:
- 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI: all RW.
- 4 CTRL: bit0 EN, bits[15:8] DIV, RW.
- 5 STATUS: bit0 = irq_o, RO.
- 6-7 unmapped.
REQ-014 Handshake: wb_ack_o registered, asserted the cycle after cyc&stb&~ack is seen, high exactly one cycle.
- Held stb yields ack on alternate cycles.
- One transfer per ack.
REQ-015 Writes commit on the ack cycle's rising edge; only lanes with wb_sel_i set are updated.
REQ-016 wb_dat_o is registered with ack; it is 0 when ack is low.
REQ-017 Prescaler: 8-bit count runs while EN=1.
- When count==DIV: count clears and mtime increments by 1.
- While EN=0: count held at 0, mtime frozen.
REQ-018 mtime is 64-bit and wraps from all-ones to 0 with no flag.
REQ-019 A bus write to MTIME_LO/HI in the same cycle as an increment wins; the written lanes take the bus value, the unwritten half keeps its pre-increment value.
REQ-020 Reading MTIME_LO captures mtime[63:32] into a shadow register; reading MTIME_HI returns the shadow, giving a coherent 64-bit read.
REQ-021 irq_o = EN & (mtime >= mtimecmp), unsigned 64-bit compare, registered (one cycle after the condition).
- irq_o is cleared only by raising mtimecmp, clearing EN or reset.
REQ-022 Writing DIV resets the prescale count to 0.
REQ-023 wb_rty_o is constant 0.

Reset
REQ-024 On wb_rst_i, asynchronously, the following are set:
- mtime=0, shadow=0, count=0, mtimecmp=RESET_CMP, EN=0, DIV=RESET_DIV.
- wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq_o=0.
REQ-025 Reset asserted mid-transfer aborts it; no ack or err is issued for that cycle afterward, and the master must re-issue.

Configuration
REQ-026 Macro WB_MTIMER_ERR_EN defined: accesses to indices 6-7 and writes to STATUS terminate with wb_err_o (same timing as ack) instead of wb_ack_o, with no state change.
REQ-027 WB_MTIMER_ERR_EN undefined: those accesses are acked, reads return 0, writes are ignored, and wb_err_o is constant 0.

Structure
REQ-028 Shared package wb_mtimer_pkg holds:
- register index constants (MTIME_LO..STATUS);
- CTRL field positions;
- register data width 32 and timer width 64.
REQ-029 One sub-module, wb_mtimer_prescaler, holds the 8-bit count and emits the one-cycle tick; the bus decode and registers stay in wb_mtimer.

Verification
REQ-030 Prescale: write CTRL=0x0000_0301 (EN=1, DIV=3) -> MTIME_LO read after 40 cycles is 10 ±1; wb_ack_o is a single-cycle pulse per access.
REQ-031 Interrupt: mtimecmp=0x20, DIV=0, EN=1 -> irq_o rises one cycle after mtime reaches 0x20; writing MTIMECMP_LO=0x100 drops irq_o next cycle.
REQ-032 Wrap and coherence: MTIME_HI=0xFFFF_FFFF, MTIME_LO=0xFFFF_FFFE, EN=1 -> wraps to 0 after 2 ticks; an LO-then-HI read pair straddling the LO-to-HI carry returns a consistent 64-bit value.
REQ-033 Byte lanes: write 0xAABB_CCDD to MTIMECMP_LO with sel=4'b0010 from 0xFFFF_FFFF -> reads back 0xFFFF_CCFF.
REQ-034 Unmapped index 6, both builds -> with WB_MTIMER_ERR_EN: err pulse, no ack; without: ack with data 0.
REQ-035 Async reset asserted between stb and ack -> no ack; all registers at reset values; irq_o=0.

Source files
------------

// File: rtl/wb_mtimer_pkg.sv
// Shared constants for the Wishbone machine timer: register word indices, CTRL field
// positions, data/timer widths and a byte-lane merge helper.
package wb_mtimer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMER_W = 64;
  localparam int unsigned SEL_W   = DATA_W / 8;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t IDX_MTIME_LO    = 3'd0;
  localparam reg_idx_t IDX_MTIME_HI    = 3'd1;
  localparam reg_idx_t IDX_MTIMECMP_LO = 3'd2;
  localparam reg_idx_t IDX_MTIMECMP_HI = 3'd3;
  localparam reg_idx_t IDX_CTRL        = 3'd4;
  localparam reg_idx_t IDX_STATUS      = 3'd5;
  localparam reg_idx_t IDX_RSVD6       = 3'd6;
  localparam reg_idx_t IDX_RSVD7       = 3'd7;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_DIV_LSB = 8;
  localparam int unsigned CTRL_DIV_W   = 8;
  // Byte lane of CTRL that carries DIV; a write enabling it restarts the prescaler.
  localparam int unsigned CTRL_DIV_LANE = CTRL_DIV_LSB / 8;

  // Replace the bytes of old_val whose sel bit is set with the matching bytes of new_val.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(SEL_W); i++) begin
      if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_mtimer_prescaler.sv
// Prescaler for the machine timer: an 8-bit count that runs while enabled and emits a
// single-cycle tick whenever it matches the divider, then restarts from zero.
module wb_mtimer_prescaler
  import wb_mtimer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [CTRL_DIV_W-1:0] div_i,
  output logic                  tick_o
);

  logic [CTRL_DIV_W-1:0] count_q, count_d;

  // Tick is combinational so mtime increments on the same edge the count clears.
  assign tick_o = en_i & (count_q == div_i);

  // Next count: held at zero while disabled or on a divider write, wraps on tick.
  always_comb begin
    if (!en_i || clr_i || tick_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_mtimer.sv
// Wishbone classic machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, level
// interrupt and a coherent LO/HI read shadow.
// Build option: define WB_MTIMER_ERR_EN to terminate accesses to indices 6-7 and writes
// to STATUS with wb_err_o instead of wb_ack_o.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter logic [TIMER_W-1:0]    RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [CTRL_DIV_W-1:0] RESET_DIV = 8'd0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic [SEL_W-1:0]  wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic              irq_o
);

  logic [TIMER_W-1:0]    mtime_q, mtime_d;
  logic [TIMER_W-1:0]    cmp_q, cmp_d;
  logic [DATA_W-1:0]     shadow_q, shadow_d;
  logic                  en_q, en_d;
  logic [CTRL_DIV_W-1:0] div_q, div_d;
  logic                  irq_q, irq_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     dat_q, dat_d;

  logic                  req;
  reg_idx_t              idx;
  logic                  bad_acc;
  logic                  wr_en;
  logic                  rd_en;
  logic                  div_clr;
  logic                  tick;
  logic [DATA_W-1:0]     ctrl_word;
  logic [DATA_W-1:0]     ctrl_new;
  logic [DATA_W-1:0]     rd_mux;

  // Burst and upper/lower address bits are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:5], wb_adr_i[1:0]};

  assign idx = wb_adr_i[4:2];
  // A new transfer is taken only when no termination is currently being presented.
  assign req = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;

`ifdef WB_MTIMER_ERR_EN
  assign bad_acc = (idx == IDX_RSVD6) || (idx == IDX_RSVD7) ||
                   (wb_we_i && (idx == IDX_STATUS));
`else
  assign bad_acc = 1'b0;
`endif

  assign wr_en   = req & ~bad_acc & wb_we_i;
  assign rd_en   = req & ~bad_acc & ~wb_we_i;
  assign div_clr = wr_en & (idx == IDX_CTRL) & wb_sel_i[CTRL_DIV_LANE];

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign irq_o    = irq_q;

  wb_mtimer_prescaler u_prescaler (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .en_i   (en_q),
    .clr_i  (div_clr),
    .div_i  (div_q),
    .tick_o (tick)
  );

  // Read data mux and CTRL image.
  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT] = en_q;
    ctrl_word[CTRL_DIV_LSB +: CTRL_DIV_W] = div_q;
    ctrl_new = lane_merge(ctrl_word, wb_dat_i, wb_sel_i);
    unique case (idx)
      IDX_MTIME_LO:    rd_mux = mtime_q[DATA_W-1:0];
      IDX_MTIME_HI:    rd_mux = shadow_q;
      IDX_MTIMECMP_LO: rd_mux = cmp_q[DATA_W-1:0];
      IDX_MTIMECMP_HI: rd_mux = cmp_q[TIMER_W-1:DATA_W];
      IDX_CTRL:        rd_mux = ctrl_word;
      IDX_STATUS:      rd_mux = {{(DATA_W-1){1'b0}}, irq_q};
      default:         rd_mux = '0;
    endcase
  end

  // Next-state for timer, compare, control, shadow and bus termination.
  always_comb begin
    mtime_d  = tick ? mtime_q + 1'b1 : mtime_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    irq_d    = en_q & (mtime_q >= cmp_q);
    ack_d    = req & ~bad_acc;
    err_d    = req & bad_acc;
    dat_d    = rd_en ? rd_mux : '0;

    // Bus writes override a coincident increment; the other half keeps its old value.
    if (wr_en) begin
      unique case (idx)
        IDX_MTIME_LO: mtime_d = {mtime_q[TIMER_W-1:DATA_W],
                                 lane_merge(mtime_q[DATA_W-1:0], wb_dat_i, wb_sel_i)};
        IDX_MTIME_HI: mtime_d = {lane_merge(mtime_q[TIMER_W-1:DATA_W], wb_dat_i, wb_sel_i),
                                 mtime_q[DATA_W-1:0]};
        IDX_MTIMECMP_LO: cmp_d[DATA_W-1:0] = lane_merge(cmp_q[DATA_W-1:0], wb_dat_i, wb_sel_i);
        IDX_MTIMECMP_HI: cmp_d[TIMER_W-1:DATA_W] =
                           lane_merge(cmp_q[TIMER_W-1:DATA_W], wb_dat_i, wb_sel_i);
        IDX_CTRL: begin
          en_d  = ctrl_new[CTRL_EN_BIT];
          div_d = ctrl_new[CTRL_DIV_LSB +: CTRL_DIV_W];
        end
        default: ;
      endcase
    end

    // Reading LO freezes the upper half so a following HI read is coherent.
    if (rd_en && (idx == IDX_MTIME_LO)) begin
      shadow_d = mtime_q[TIMER_W-1:DATA_W];
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mtime_q  <= '0;
      cmp_q    <= RESET_CMP;
      shadow_q <= '0;
      en_q     <= 1'b0;
      div_q    <= RESET_DIV;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      en_q     <= en_d;
      div_q    <= div_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
    end
  end

endmodule
